ahb_mux_s2m: RTL and testbench

- Slave-to-master multiplexer for one AHB bus segment. Returns HRDATA, HREADY and HRESP from up to four slaves to the active master.
- Registers the decoder's slave select at the end of each address phase, so response routing follows the data phase.
- Contains a default slave that answers transfers to unmapped addresses with a standard two-cycle ERROR response.
- Sits between the slave ports and the masters/arbiter; it is the return-path counterpart of the master-to-slave mux.

---
 rtl/ahb_mux_s2m_pkg.sv | 33 +++
 rtl/ahb_mux_s2m_if.sv | 23 ++
 rtl/ahb_default_slave.sv | 52 +++++
 rtl/ahb_mux_s2m.sv | 92 +++++++++
 tb/tb_ahb_mux_s2m.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_mux_s2m_pkg.sv
// Shared AHB encodings and helpers for the slave-to-master return mux.
// HTRANS/HRESP codes and the default-slave state encoding live here.
package ahb_mux_s2m_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int unsigned NumSlaves = 4;

  typedef enum logic [1:0] {
    DsIdle = 2'b00,
    DsErr1 = 2'b01,
    DsErr2 = 2'b10
  } ds_state_e;

  // Lowest-index select wins; no select maps to the default slave (bit 4).
  function automatic logic [4:0] sel_encode(input logic [3:0] hsel);
    logic [4:0] sel;
    sel = 5'b1_0000;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if (hsel[i]) sel = 5'(1 << i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/ahb_mux_s2m_if.sv
// Slave-side and master-side signals of the AHB return-path mux.
// The "slave" modport is the mux itself; "master" is whoever drives the slave returns.
interface ahb_mux_s2m_if;
  logic [1:0]  htrans;
  logic [3:0]  hsel;
  logic [31:0] hrdata_x [4];
  logic [3:0]  hready_x;
  logic [1:0]  hresp_x  [4];
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [4:0]  hseld;

  modport slave (
    input  htrans, hsel, hrdata_x, hready_x, hresp_x,
    output hrdata, hready, hresp, hseld
  );

  modport master (
    output htrans, hsel, hrdata_x, hready_x, hresp_x,
    input  hrdata, hready, hresp, hseld
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR for NONSEQ/SEQ
// to unmapped space. err_entry flags every edge that enters DsErr1.
module ahb_default_slave
  import ahb_mux_s2m_pkg::*;
#(
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [1:0]  htrans,
  input  logic        nosel,
  input  logic        hready,
  output logic        ds_hready,
  output logic [1:0]  ds_hresp,
  output logic [31:0] ds_hrdata,
  output logic        err_entry
);

  ds_state_e state_q, state_d;
  logic      unmapped_xfer;

  assign unmapped_xfer = hready && nosel &&
                         (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= DsIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    ds_hrdata = DEFAULT_RDATA;
    unique case (state_q)
      DsIdle: if (unmapped_xfer) state_d = DsErr1;
      DsErr1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        state_d   = DsErr2;
      end
      DsErr2: begin
        ds_hresp = HRESP_ERROR;
        state_d  = unmapped_xfer ? DsErr1 : DsIdle;
      end
      default: state_d = DsIdle;
    endcase
  end

  assign err_entry = (state_d == DsErr1);

endmodule

// File: rtl/ahb_mux_s2m.sv
// AHB slave-to-master mux: registers the decoder select for the data phase and
// returns HRDATA/HREADY/HRESP. Optional error counter under AHB_MUX_S2M_ERRCNT_EN.
module ahb_mux_s2m
  import ahb_mux_s2m_pkg::*;
#(
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
`ifdef AHB_MUX_S2M_ERRCNT_EN
  input  logic        errcnt_clr,
  output logic [7:0]  errcnt,
`endif
  ahb_mux_s2m_if.slave bus
);

  logic [4:0]  hseld_q;
  logic        nosel;
  logic        ds_hready;
  logic [1:0]  ds_hresp;
  logic [31:0] ds_hrdata;
  logic        err_entry;

  assign nosel = ~|bus.hsel;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)          hseld_q <= 5'b1_0000;
    else if (bus.hready) hseld_q <= sel_encode(bus.hsel);
  end

  assign bus.hseld = hseld_q;

  ahb_default_slave #(
    .DEFAULT_RDATA (DEFAULT_RDATA)
  ) u_default_slave (
    .hclk      (hclk),
    .hreset    (hreset),
    .htrans    (bus.htrans),
    .nosel     (nosel),
    .hready    (bus.hready),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .ds_hrdata (ds_hrdata),
    .err_entry (err_entry)
  );

  always_comb begin
    bus.hrdata = ds_hrdata;
    bus.hready = ds_hready;
    bus.hresp  = ds_hresp;
    unique case (hseld_q)
      5'b0_0001: begin
        bus.hrdata = bus.hrdata_x[0];
        bus.hready = bus.hready_x[0];
        bus.hresp  = bus.hresp_x[0];
      end
      5'b0_0010: begin
        bus.hrdata = bus.hrdata_x[1];
        bus.hready = bus.hready_x[1];
        bus.hresp  = bus.hresp_x[1];
      end
      5'b0_0100: begin
        bus.hrdata = bus.hrdata_x[2];
        bus.hready = bus.hready_x[2];
        bus.hresp  = bus.hresp_x[2];
      end
      5'b0_1000: begin
        bus.hrdata = bus.hrdata_x[3];
        bus.hready = bus.hready_x[3];
        bus.hresp  = bus.hresp_x[3];
      end
      default: ;
    endcase
  end

`ifdef AHB_MUX_S2M_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Clear takes priority over a same-edge increment; count saturates at 8'hFF.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                               errcnt_q <= 8'h00;
    else if (errcnt_clr)                      errcnt_q <= 8'h00;
    else if (err_entry && errcnt_q != 8'hFF)  errcnt_q <= errcnt_q + 8'h01;
  end

  assign errcnt = errcnt_q;
`else
  logic unused_err_entry;
  assign unused_err_entry = err_entry;
`endif

endmodule

// File: tb/tb_ahb_mux_s2m.sv
// Directed bench for ahb_mux_s2m; also covers the error counter when
// AHB_MUX_S2M_ERRCNT_EN is defined.
module tb_ahb_mux_s2m;
  import ahb_mux_s2m_pkg::*;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_fail;

  ahb_mux_s2m_if bus ();

`ifdef AHB_MUX_S2M_ERRCNT_EN
  logic       errcnt_clr;
  logic [7:0] errcnt;
`endif

  ahb_mux_s2m #(
    .DEFAULT_RDATA (32'h0000_0000)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
`ifdef AHB_MUX_S2M_ERRCNT_EN
    .errcnt_clr (errcnt_clr),
    .errcnt     (errcnt),
`endif
    .bus        (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic rdy, input logic [1:0] rsp);
    check_eq(tag, {29'd0, bus.hready, bus.hresp}, {29'd0, rdy, rsp});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hreset   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hsel   = 4'b0000;
    bus.hready_x = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.hrdata_x[i] = 32'h1111_0000 * (i + 1);
      bus.hresp_x[i]  = HRESP_OKAY;
    end
`ifdef AHB_MUX_S2M_ERRCNT_EN
    errcnt_clr = 1'b0;
`endif

    // Asynchronous reset before any clock edge
    #2 hreset = 1'b1;
    #1;
    check_eq("rst_hseld", {27'd0, bus.hseld}, 32'h10);
    check_rsp("rst_rsp", 1'b1, HRESP_OKAY);
    check_eq("rst_hrdata", bus.hrdata, 32'h0);
`ifdef AHB_MUX_S2M_ERRCNT_EN
    check_eq("rst_errcnt", {24'd0, errcnt}, 32'h0);
`endif
    tick();
    tick();
    hreset = 1'b0;

    // Mapped read to slave 2 with two wait states
    bus.hsel = 4'b0100; bus.htrans = HTRANS_NONSEQ;
    tick();
    bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
    bus.hready_x[2] = 1'b0; bus.hrdata_x[2] = 32'hDEAD_BEEF;
    #1;
    check_eq("rd_hseld", {27'd0, bus.hseld}, 32'h04);
    check_eq("rd_wait1", {31'd0, bus.hready}, 32'h0);
    tick();
    check_eq("rd_wait2", {31'd0, bus.hready}, 32'h0);
    check_eq("rd_hold", {27'd0, bus.hseld}, 32'h04);
    tick();
    bus.hready_x[2] = 1'b1;
    #1;
    check_rsp("rd_done", 1'b1, HRESP_OKAY);
    check_eq("rd_data", bus.hrdata, 32'hDEAD_BEEF);
    tick();
    check_eq("rd_back_dflt", {27'd0, bus.hseld}, 32'h10);
    check_rsp("rd_idle_okay", 1'b1, HRESP_OKAY);

    // Single unmapped NONSEQ
`ifdef AHB_MUX_S2M_ERRCNT_EN
    errcnt_clr = 1'b1;
    tick();
    errcnt_clr = 1'b0;
`endif
    bus.htrans = HTRANS_NONSEQ;
    tick();
    bus.htrans = HTRANS_IDLE;
    #1;
    check_rsp("err_c1", 1'b0, HRESP_ERROR);
    tick();
    check_rsp("err_c2", 1'b1, HRESP_ERROR);
    tick();
    check_rsp("err_done", 1'b1, HRESP_OKAY);
    check_eq("err_rdata", bus.hrdata, 32'h0);
`ifdef AHB_MUX_S2M_ERRCNT_EN
    check_eq("cnt_one", {24'd0, errcnt}, 32'h1);
    errcnt_clr = 1'b1;
    tick();
    errcnt_clr = 1'b0;
`endif

    // Back-to-back unmapped NONSEQ then SEQ
    bus.htrans = HTRANS_NONSEQ;
    tick();
    bus.htrans = HTRANS_SEQ;
    #1;
    check_rsp("b2b_c1", 1'b0, HRESP_ERROR);
    tick();
    check_rsp("b2b_c2", 1'b1, HRESP_ERROR);
    tick();
    bus.htrans = HTRANS_IDLE;
    #1;
    check_rsp("b2b_c3", 1'b0, HRESP_ERROR);
    tick();
    check_rsp("b2b_c4", 1'b1, HRESP_ERROR);
    tick();
    check_rsp("b2b_done", 1'b1, HRESP_OKAY);
`ifdef AHB_MUX_S2M_ERRCNT_EN
    check_eq("cnt_b2b", {24'd0, errcnt}, 32'h2);
`endif

    // Unmapped BUSY: zero-wait OKAY
    bus.htrans = HTRANS_BUSY;
    tick();
    bus.htrans = HTRANS_IDLE;
    #1;
    check_rsp("busy_okay", 1'b1, HRESP_OKAY);

    // Priority (1 beats 3) and hold during wait state
    bus.hsel = 4'b1010; bus.htrans = HTRANS_NONSEQ;
    bus.hrdata_x[1] = 32'h0BAD_F00D; bus.hresp_x[1] = HRESP_OKAY;
    tick();
    bus.hready_x[1] = 1'b0; bus.hsel = 4'b0001;
    #1;
    check_eq("pri_hseld", {27'd0, bus.hseld}, 32'h02);
    check_eq("pri_wait", {31'd0, bus.hready}, 32'h0);
    tick();
    check_eq("pri_hold", {27'd0, bus.hseld}, 32'h02);
    bus.hready_x[1] = 1'b1;
    #1;
    check_eq("pri_data", bus.hrdata, 32'h0BAD_F00D);
    tick();
    check_eq("pri_s0", {27'd0, bus.hseld}, 32'h01);
    bus.hresp_x[0] = HRESP_RETRY;
    #1;
    check_rsp("pri_s0_rsp", 1'b1, HRESP_RETRY);
    bus.hresp_x[0] = HRESP_OKAY;

    // Mapped transfer captured during DsErr2
    bus.hsel = 4'b0000; bus.htrans = HTRANS_NONSEQ;
    tick();
    check_rsp("sim_c1", 1'b0, HRESP_ERROR);
    tick();
    bus.hsel = 4'b0001;
    #1;
    check_rsp("sim_c2", 1'b1, HRESP_ERROR);
    tick();
    check_eq("sim_hseld", {27'd0, bus.hseld}, 32'h01);
    bus.hsel = 4'b0000; bus.htrans = HTRANS_IDLE;
    tick();
    check_rsp("sim_ds_idle", 1'b1, HRESP_OKAY);

    // Asynchronous reset while in DsErr1
    bus.htrans = HTRANS_NONSEQ;
    tick();
    check_rsp("mid_err1", 1'b0, HRESP_ERROR);
    #2 hreset = 1'b1;
    #1;
    check_rsp("mid_rst_rsp", 1'b1, HRESP_OKAY);
    check_eq("mid_rst_hseld", {27'd0, bus.hseld}, 32'h10);
    bus.htrans = HTRANS_IDLE;
    tick();
    hreset = 1'b0;
    tick();
    check_rsp("post_rst", 1'b1, HRESP_OKAY);

`ifdef AHB_MUX_S2M_ERRCNT_EN
    // Saturation: 300 back-to-back error entries over 600 edges
    bus.htrans = HTRANS_NONSEQ;
    for (int i = 0; i < 600; i++) tick();
    bus.htrans = HTRANS_IDLE;
    tick();
    tick();
    check_eq("cnt_sat", {24'd0, errcnt}, 32'hFF);
    check_rsp("sat_idle", 1'b1, HRESP_OKAY);
    // Clear coinciding with a new entry into DsErr1
    bus.htrans = HTRANS_NONSEQ; errcnt_clr = 1'b1;
    tick();
    bus.htrans = HTRANS_IDLE; errcnt_clr = 1'b0;
    #1;
    check_rsp("clr_err1", 1'b0, HRESP_ERROR);
    check_eq("cnt_clr", {24'd0, errcnt}, 32'h0);
    tick();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
